// File: rtl/filt_mem_server_pkg.sv
// Shared definitions for the FIR memory/control server.
// Holds the FSM state type and the default geometry of the filter memories.
package filt_mem_server_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitDone = 2'd2,
    StOutput   = 2'd3
  } state_e;

  localparam int unsigned DefM        = 23;
  localparam int unsigned DefAddrSize = 5;
  localparam int unsigned DefDataSize = 16;
  localparam int unsigned DefCoefSize = 32;
  localparam int unsigned DefTimeout  = 255;

endpackage

// File: rtl/filt_mem_server_sample_ram.sv
// M-entry sample ring addressed by logical age (k = 0 is the newest sample).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     store a new sample (advances head, grows fill up to M)
//   rd_ce, rd_addr      read enable and logical index k
//   rd_data             registered read data; 0 for k >= fill or k >= M; holds when rd_ce = 0
// Storage contents are not cleared by reset; fill = 0 masks stale entries instead.
module filt_mem_server_sample_ram
  import filt_mem_server_pkg::*;
#(
  parameter int unsigned M         = DefM,
  parameter int unsigned ADDR_SIZE = DefAddrSize,
  parameter int unsigned DATA_SIZE = DefDataSize
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 rd_ce,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  localparam logic [ADDR_SIZE-1:0] MW    = ADDR_SIZE'(M);
  localparam logic [ADDR_SIZE-1:0] MLast = ADDR_SIZE'(M - 1);

  logic [DATA_SIZE-1:0] ram [M];
  logic [ADDR_SIZE-1:0] head_q, head_nxt;
  logic [ADDR_SIZE-1:0] fill_q;
  logic [ADDR_SIZE-1:0] phys;
  logic                 hit;
  logic [DATA_SIZE-1:0] rd_q;

  assign head_nxt = (head_q == MLast) ? '0 : head_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= MLast;
      fill_q <= '0;
    end else if (push) begin
      head_q <= head_nxt;
      if (fill_q != MW) fill_q <= fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ram[head_nxt] <= push_data;
  end

  // When k > head the modular result head + M - k is below M, so plain
  // ADDR_SIZE-bit arithmetic is exact in both branches.
  assign phys = (rd_addr <= head_q) ? head_q - rd_addr : head_q + MW - rd_addr;
  assign hit  = (rd_addr < fill_q) && (rd_addr < MW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_ce) begin
      rd_q <= hit ? ram[phys] : '0;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/filt_mem_server.sv
// Memory/control server for an HLS FIR core with ap_ctrl_hs + ap_memory ports.
// Accepts one sample per s handshake into a sample ring, starts the core, serves its
// sample/coefficient reads, and returns ap_return on the m stream.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_valid/s_ready/s_data        sample input stream
//   m_valid/m_ready/m_data        result output stream
//   timeout_err                   result is a timeout substitute
//   coef_we/coef_addr/coef_wdata  coefficient write (IDLE only, addr < M)
//   ap_start, ap_done/idle/ready  core control
//   ap_return                     core result
//   x_ant_*, x_coefs_*            core-side sample and coefficient read ports
//   busy                          FSM not idle
// Build option: FILT_TIMEOUT_EN adds a WAIT_DONE watchdog of TIMEOUT cycles.
module filt_mem_server
  import filt_mem_server_pkg::*;
#(
  parameter int unsigned M         = DefM,
  parameter int unsigned ADDR_SIZE = DefAddrSize,
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned COEF_SIZE = DefCoefSize,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 timeout_err,
  input  logic                 coef_we,
  input  logic [ADDR_SIZE-1:0] coef_addr,
  input  logic [COEF_SIZE-1:0] coef_wdata,
  output logic                 ap_start,
  input  logic                 ap_done,
  input  logic                 ap_idle,
  input  logic                 ap_ready,
  input  logic [DATA_SIZE-1:0] ap_return,
  input  logic [ADDR_SIZE-1:0] x_ant_address0,
  input  logic                 x_ant_ce0,
  output logic [DATA_SIZE-1:0] x_ant_q0,
  input  logic [ADDR_SIZE-1:0] x_coefs_address0,
  input  logic                 x_coefs_ce0,
  output logic [COEF_SIZE-1:0] x_coefs_q0,
  output logic                 busy
);

  localparam logic [ADDR_SIZE-1:0] MW = ADDR_SIZE'(M);

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] m_data_q, m_data_d;
  logic [COEF_SIZE-1:0] coef_q [M];
  logic [COEF_SIZE-1:0] coef_rd_q;
  logic                 push;
  logic                 timeout_hit;

  assign s_ready  = (state_q == StIdle) && !rst;
  assign push     = s_valid && s_ready;
  assign ap_start = (state_q == StStart);
  assign m_valid  = (state_q == StOutput);
  assign busy     = (state_q != StIdle);
  assign m_data   = m_data_q;

  filt_mem_server_sample_ram #(
    .M         (M),
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_sample_ram (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .rd_ce     (x_ant_ce0),
    .rd_addr   (x_ant_address0),
    .rd_data   (x_ant_q0)
  );

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    unique case (state_q)
      StIdle: if (push) state_d = StStart;
      StStart: begin
        if (ap_ready) begin
          if (ap_done) begin
            m_data_d = ap_return;
            state_d  = StOutput;
          end else begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (ap_done) begin
          m_data_d = ap_return;
          state_d  = StOutput;
        end else if (timeout_hit) begin
          m_data_d = '0;
          state_d  = StOutput;
        end
      end
      StOutput: if (m_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
    end
  end

  // Coefficient register file: writes only while idle so the core never sees it change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(M); i++) coef_q[i] <= '0;
      coef_rd_q <= '0;
    end else begin
      if (coef_we && (state_q == StIdle) && (coef_addr < MW)) coef_q[coef_addr] <= coef_wdata;
      if (x_coefs_ce0) coef_rd_q <= (x_coefs_address0 < MW) ? coef_q[x_coefs_address0] : '0;
    end
  end

  assign x_coefs_q0 = coef_rd_q;

`ifdef FILT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            terr_q;

  // Fires on the TIMEOUT-th cycle spent in WAIT_DONE.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == StWaitDone) ? cnt_q + 1'b1 : '0;
      if ((state_q == StWaitDone) && !ap_done && timeout_hit) begin
        terr_q <= 1'b1;
      end else if ((state_q == StOutput) && m_ready) begin
        terr_q <= 1'b0;
      end
    end
  end

  assign timeout_err = terr_q;

  logic unused_inputs;
  assign unused_inputs = ap_idle;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ap_idle ^ (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_filt_mem_server.sv
// Directed self-checking bench for filt_mem_server.
module tb_filt_mem_server;

  localparam int unsigned M  = 23;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          timeout_err;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;
  logic          ap_start, ap_done, ap_idle, ap_ready;
  logic [DW-1:0] ap_return;
  logic [AW-1:0] x_ant_address0;
  logic          x_ant_ce0;
  logic [DW-1:0] x_ant_q0;
  logic [AW-1:0] x_coefs_address0;
  logic          x_coefs_ce0;
  logic [CW-1:0] x_coefs_q0;
  logic          busy;

  int total = 0;
  int bad   = 0;

  filt_mem_server dut (
    .clk              (clk),
    .rst              (rst),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .timeout_err      (timeout_err),
    .coef_we          (coef_we),
    .coef_addr        (coef_addr),
    .coef_wdata       (coef_wdata),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .ap_return        (ap_return),
    .x_ant_address0   (x_ant_address0),
    .x_ant_ce0        (x_ant_ce0),
    .x_ant_q0         (x_ant_q0),
    .x_coefs_address0 (x_coefs_address0),
    .x_coefs_ce0      (x_coefs_ce0),
    .x_coefs_q0       (x_coefs_q0),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction with an instantly responding core and consumer.
  task automatic push_fast(input logic [DW-1:0] v);
    ap_ready = 1'b1; ap_done = 1'b1; ap_return = 16'h0; m_ready = 1'b1;
    s_valid = 1'b1; s_data = v;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    ap_ready = 1'b0; ap_done = 1'b0; m_ready = 1'b0;
  endtask

  task automatic rd_ant(input logic [AW-1:0] k);
    x_ant_address0 = k; x_ant_ce0 = 1'b1;
    tick();
    x_ant_ce0 = 1'b0;
  endtask

  task automatic rd_coef(input logic [AW-1:0] a);
    x_coefs_address0 = a; x_coefs_ce0 = 1'b1;
    tick();
    x_coefs_ce0 = 1'b0;
  endtask

  task automatic wr_coef(input logic [AW-1:0] a, input logic [CW-1:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    tick();
    coef_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 0; s_data = 0; m_ready = 0; coef_we = 0; coef_addr = 0; coef_wdata = 0;
    ap_done = 0; ap_idle = 1; ap_ready = 0; ap_return = 0;
    x_ant_address0 = 0; x_ant_ce0 = 0; x_coefs_address0 = 0; x_coefs_ce0 = 0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_ap_start", 32'(ap_start), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_ant_q0", 32'(x_ant_q0), 0);
    chk("rst_coef_q0", 32'(x_coefs_q0), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);

    // Three pushes, then read back by age.
    push_fast(16'd1); push_fast(16'd2); push_fast(16'd3);
    rd_ant(5'd0); chk("ant_k0", 32'(x_ant_q0), 3);
    rd_ant(5'd1); chk("ant_k1", 32'(x_ant_q0), 2);
    x_ant_address0 = 5'd0;
    tick();
    chk("ant_hold", 32'(x_ant_q0), 2);
    rd_ant(5'd2); chk("ant_k2", 32'(x_ant_q0), 1);
    rd_ant(5'd3); chk("ant_k3_unfilled", 32'(x_ant_q0), 0);

    // Fill past M: 25 samples total, head wraps.
    for (int v = 4; v <= 25; v++) push_fast(16'(v));
    rd_ant(5'd0);  chk("wrap_k0", 32'(x_ant_q0), 25);
    rd_ant(5'd22); chk("wrap_k22", 32'(x_ant_q0), 3);
    rd_ant(5'd23); chk("wrap_k23", 32'(x_ant_q0), 0);
    rd_ant(5'd31); chk("wrap_k31", 32'(x_ant_q0), 0);

    // Coefficient write in IDLE.
    wr_coef(5'd4, 32'hDEADBEEF);
    rd_coef(5'd4);  chk("coef4", x_coefs_q0, 32'hDEADBEEF);
    rd_coef(5'd5);  chk("coef5_reset", x_coefs_q0, 0);
    rd_coef(5'd23); chk("coef23_oob", x_coefs_q0, 0);

    // Slow core: ap_ready delayed 4 cycles.
    s_valid = 1'b1; s_data = 16'd26;
    tick();
    s_valid = 1'b0;
    chk("start_s_ready", 32'(s_ready), 0);
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      chk("start_held", 32'(ap_start), 1);
      tick();
    end
    ap_ready = 1'b1;
    chk("start_cycle5", 32'(ap_start), 1);
    tick();
    ap_ready = 1'b0;
    chk("wait_ap_start", 32'(ap_start), 0);
    chk("wait_m_valid", 32'(m_valid), 0);
    chk("wait_busy", 32'(busy), 1);
    wr_coef(5'd4, 32'h12345678);
    ap_done = 1'b1; ap_return = 16'h1234;
    tick();
    ap_done = 1'b0; ap_return = 16'h0BAD;
    chk("out_m_valid", 32'(m_valid), 1);
    chk("out_m_data", 32'(m_data), 32'h1234);

    // Back-pressure with sample pulses that must be ignored.
    for (int i = 0; i < 10; i++) begin
      s_valid = i[0]; s_data = 16'hEEEE;
      tick();
      chk("bp_m_valid", 32'(m_valid), 1);
      chk("bp_m_data", 32'(m_data), 32'h1234);
      chk("bp_s_ready", 32'(s_ready), 0);
    end
    s_valid = 1'b0;
    rd_ant(5'd0); chk("bp_head_kept", 32'(x_ant_q0), 26);
    rd_coef(5'd4); chk("coef_wait_write_ignored", x_coefs_q0, 32'hDEADBEEF);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("done_m_valid", 32'(m_valid), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_s_ready", 32'(s_ready), 1);

    // Coefficient write and sample push in the same cycle.
    coef_we = 1'b1; coef_addr = 5'd7; coef_wdata = 32'h0000AA55;
    ap_ready = 1'b1; ap_done = 1'b1; m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'd27;
    tick();
    coef_we = 1'b0; s_valid = 1'b0;
    tick(); tick();
    ap_ready = 1'b0; ap_done = 1'b0; m_ready = 1'b0;
    rd_coef(5'd7); chk("coef7_with_push", x_coefs_q0, 32'h0000AA55);
    rd_ant(5'd0);  chk("push_with_coef", 32'(x_ant_q0), 27);

`ifdef FILT_TIMEOUT_EN
    // Core never finishes: watchdog substitutes a zero result.
    begin
      int waited;
      ap_ready = 1'b1; ap_return = 16'h5555;
      s_valid = 1'b1; s_data = 16'd28;
      tick();
      s_valid = 1'b0;
      tick();
      ap_ready = 1'b0;
      waited = 0;
      while (!m_valid && waited < 400) begin
        tick();
        waited++;
      end
      chk("to_m_valid", 32'(m_valid), 1);
      chk("to_wait_cycles", 32'(waited), 255);
      chk("to_m_data", 32'(m_data), 0);
      chk("to_err", 32'(timeout_err), 1);
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      chk("to_late_done_ignored", 32'(m_data), 0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("to_err_cleared", 32'(timeout_err), 0);
    end
`else
    chk("no_timeout_err", 32'(timeout_err), 0);
`endif

    // Reset mid-transaction.
    s_valid = 1'b1; s_data = 16'd29;
    tick();
    s_valid = 1'b0;
    chk("pre_rst_ap_start", 32'(ap_start), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ap_start", 32'(ap_start), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_s_ready", 32'(s_ready), 1);
    rd_ant(5'd0);  chk("postrst_ant_empty", 32'(x_ant_q0), 0);
    rd_coef(5'd4); chk("postrst_coef_cleared", x_coefs_q0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
